// File: rtl/axes_pkg.sv
// Shared constants and helpers for the plot-axes renderer: default geometry,
// coordinate widths of the 640x480 panel, and the arrowhead length rule.
package axes_pkg;

    localparam int DEFAULT_SCREEN_W = 640;
    localparam int DEFAULT_SCREEN_H = 480;
    localparam int DEFAULT_XW       = $clog2(DEFAULT_SCREEN_W);
    localparam int DEFAULT_YW       = $clog2(DEFAULT_SCREEN_H);

    localparam int DEFAULT_OFF  = 7;
    localparam int DEFAULT_WLEN = 600;
    localparam int DEFAULT_HLEN = 450;

    typedef enum logic {
        CFG_IDLE = 1'b0,
        CFG_PEND = 1'b1
    } cfg_state_t;

    // Arrowhead length along the axis: twice the line thickness.
    function automatic int arr_len(input int width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/tick_phase_ctr.sv
// Modulo-TICK_SP phase counter: cleared when the coordinate hits the origin,
// otherwise advances and wraps, so phase==0 marks every TICK_SP-th coordinate.
module tick_phase_ctr #(
    parameter int TICK_SP = 50,
    parameter int PW      = $clog2(TICK_SP)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          step,
    input  logic          clear,
    output logic [PW-1:0] phase
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
        end else if (step) begin
            if (clear) begin
                phase <= '0;
            end else if (phase == PW'(TICK_SP - 1)) begin
                phase <= '0;
            end else begin
                phase <= phase + 1'b1;
            end
        end
    end

endmodule

// File: rtl/axes_grid_renderer.sv
// Two-stage plot-axes renderer: classifies each raster pixel as axis, arrowhead,
// tick or grid line, with axis geometry reloaded only at frame start.
module axes_grid_renderer
    import axes_pkg::*;
#(
    parameter int SCREEN_W = DEFAULT_SCREEN_W,
    parameter int SCREEN_H = DEFAULT_SCREEN_H,
    parameter int WIDTH    = 5,
    parameter int TICK_SP  = 50,
    parameter int TICK_LEN = 4,
    parameter int DEF_OFF  = DEFAULT_OFF,
    parameter int DEF_WLEN = DEFAULT_WLEN,
    parameter int DEF_HLEN = DEFAULT_HLEN
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [$clog2(SCREEN_W)-1:0] px,
    input  logic [$clog2(SCREEN_H)-1:0] py,
    input  logic                        pix_valid,
    input  logic                        sof,
    input  logic                        en,
    input  logic                        grid_en,
    input  logic [$clog2(SCREEN_H)-1:0] cfg_off,
    input  logic [$clog2(SCREEN_W)-1:0] cfg_wlen,
    input  logic [$clog2(SCREEN_H)-1:0] cfg_hlen,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    output logic                        out_valid,
    output logic                        axis_o,
    output logic                        arrow_o,
    output logic                        tick_o,
    output logic                        grid_o,
    output logic                        line_o
);

    localparam int XW  = $clog2(SCREEN_W);
    localparam int YW  = $clog2(SCREEN_H);
    localparam int CW  = ((XW > YW) ? XW : YW) + 2;
    localparam int HW  = WIDTH / 2;
    localparam int ARR = arr_len(WIDTH);
    localparam int PW  = $clog2(TICK_SP);

    localparam logic [CW-1:0] HW_C   = CW'(HW);
    localparam logic [CW-1:0] TICK_C = CW'(HW + TICK_LEN);
    localparam logic [CW-1:0] ARR_C  = CW'(ARR);

    // ---------------- configuration handshake ----------------
    cfg_state_t    cfg_state, cfg_state_nxt;
    logic          cfg_xfer;
    logic          frame_start;
    logic          geom_load;
    logic [YW-1:0] sh_off,  act_off,  cur_off;
    logic [XW-1:0] sh_wlen, act_wlen, cur_wlen;
    logic [YW-1:0] sh_hlen, act_hlen, cur_hlen;

    assign frame_start = sof & pix_valid;
    assign geom_load   = (cfg_state == CFG_PEND) && frame_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_state <= CFG_IDLE;
        end else begin
            cfg_state <= cfg_state_nxt;
        end
    end

    always_comb begin
        cfg_state_nxt = cfg_state;
        cfg_ready     = 1'b0;
        cfg_xfer      = 1'b0;
        case (cfg_state)
            CFG_IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    cfg_xfer      = 1'b1;
                    cfg_state_nxt = CFG_PEND;
                end
            end
            CFG_PEND: begin
                if (frame_start) begin
                    cfg_state_nxt = CFG_IDLE;
                end
            end
            default: cfg_state_nxt = CFG_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_off  <= '0;
            sh_wlen <= '0;
            sh_hlen <= '0;
        end else if (cfg_xfer) begin
            sh_off  <= cfg_off;
            sh_wlen <= cfg_wlen;
            sh_hlen <= cfg_hlen;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_off  <= YW'(DEF_OFF);
            act_wlen <= XW'(DEF_WLEN);
            act_hlen <= YW'(DEF_HLEN);
        end else if (geom_load) begin
            act_off  <= sh_off;
            act_wlen <= sh_wlen;
            act_hlen <= sh_hlen;
        end
    end

    // The sof pixel that loads new geometry is itself rendered with it.
    assign cur_off  = geom_load ? sh_off  : act_off;
    assign cur_wlen = geom_load ? sh_wlen : act_wlen;
    assign cur_hlen = geom_load ? sh_hlen : act_hlen;

    // ---------------- stage 1: distances, ranges, phases ----------------
    logic [CW-1:0] px_w, py_w, off_w, x_end, y_end, dx, dy;

    assign px_w  = CW'(px);
    assign py_w  = CW'(py);
    assign off_w = CW'(cur_off);
    assign x_end = off_w + CW'(cur_wlen);
    assign y_end = off_w + CW'(cur_hlen);
    assign dx    = (px_w >= off_w) ? (px_w - off_w) : (off_w - px_w);
    assign dy    = (py_w >= off_w) ? (py_w - off_w) : (off_w - py_w);

    logic          s1_valid, s1_en, s1_grid_en;
    logic [CW-1:0] s1_dx, s1_dy, s1_kx, s1_ky;
    logic          s1_x_body, s1_y_body, s1_x_in, s1_y_in, s1_x_arr, s1_y_arr;
    logic [PW-1:0] xph, yph;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_en      <= 1'b0;
            s1_grid_en <= 1'b0;
            s1_dx      <= '0;
            s1_dy      <= '0;
            s1_kx      <= '0;
            s1_ky      <= '0;
            s1_x_body  <= 1'b0;
            s1_y_body  <= 1'b0;
            s1_x_in    <= 1'b0;
            s1_y_in    <= 1'b0;
            s1_x_arr   <= 1'b0;
            s1_y_arr   <= 1'b0;
        end else begin
            s1_valid   <= pix_valid;
            s1_en      <= en;
            s1_grid_en <= grid_en;
            s1_dx      <= dx;
            s1_dy      <= dy;
            s1_kx      <= px_w - x_end;
            s1_ky      <= py_w - y_end;
            s1_x_body  <= (px_w >= off_w) && (px_w < x_end);
            s1_y_body  <= (py_w >= off_w) && (py_w < y_end);
            s1_x_in    <= (px_w > off_w) && (px_w < x_end);
            s1_y_in    <= (py_w > off_w) && (py_w < y_end);
            s1_x_arr   <= (px_w >= x_end) && (px_w < x_end + ARR_C);
            s1_y_arr   <= (py_w >= y_end) && (py_w < y_end + ARR_C);
        end
    end

    // Phase registers update on the same edge as stage 1, so they hold the
    // post-update phase of the pixel currently in stage 1.
    tick_phase_ctr #(.TICK_SP(TICK_SP), .PW(PW)) u_xph (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (pix_valid),
        .clear (px_w == off_w),
        .phase (xph)
    );

    tick_phase_ctr #(.TICK_SP(TICK_SP), .PW(PW)) u_yph (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (pix_valid && (px == '0)),
        .clear (py_w == off_w),
        .phase (yph)
    );

    // ---------------- stage 2: classification ----------------
    logic          ax, ar, tk, gr, gate;
    logic [CW-1:0] lim_x, lim_y;

    always_comb begin
        lim_x = (ARR_C - s1_kx) >> 1;
        lim_y = (ARR_C - s1_ky) >> 1;
        ax    = (s1_x_body && (s1_dy <= HW_C)) || (s1_y_body && (s1_dx <= HW_C));
        ar    = (s1_x_arr && (s1_dy <= lim_x)) || (s1_y_arr && (s1_dx <= lim_y));
        tk    = ((xph == '0) && s1_x_in && (s1_dy > HW_C) && (s1_dy <= TICK_C)) ||
                ((yph == '0) && s1_y_in && (s1_dx > HW_C) && (s1_dx <= TICK_C));
        gr    = s1_grid_en && ((xph == '0) || (yph == '0)) && s1_x_in && s1_y_in && !ax;
        gate  = s1_valid && s1_en;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            axis_o    <= 1'b0;
            arrow_o   <= 1'b0;
            tick_o    <= 1'b0;
            grid_o    <= 1'b0;
            line_o    <= 1'b0;
        end else begin
            out_valid <= s1_valid;
            axis_o    <= gate && ax;
            arrow_o   <= gate && ar;
            tick_o    <= gate && tk;
            grid_o    <= gate && gr;
            line_o    <= gate && (ax || ar || tk || gr);
        end
    end

endmodule

// File: tb/tb_axes_grid_renderer.sv
// Self-checking bench for axes_grid_renderer: every pixel is scored against a
// plain-arithmetic reference, plus a table of hand-derived pixel classifications.
`timescale 1ns/1ps
module tb_axes_grid_renderer;

    localparam int SW   = 640;
    localparam int SH   = 480;
    localparam int XW   = 10;
    localparam int YW   = 9;
    localparam int HW   = 2;
    localparam int ARR  = 10;
    localparam int TSP  = 50;
    localparam int TLEN = 4;
    localparam int QW   = 25;   // {valid, key[18:0], axis, arrow, tick, grid, line}

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [XW-1:0] px = '0;
    logic [YW-1:0] py = '0;
    logic          pix_valid = 1'b0, sof = 1'b0, en = 1'b0, grid_en = 1'b0;
    logic [YW-1:0] cfg_off = '0;
    logic [XW-1:0] cfg_wlen = '0;
    logic [YW-1:0] cfg_hlen = '0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready, out_valid, axis_o, arrow_o, tick_o, grid_o, line_o;

    axes_grid_renderer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .px        (px),
        .py        (py),
        .pix_valid (pix_valid),
        .sof       (sof),
        .en        (en),
        .grid_en   (grid_en),
        .cfg_off   (cfg_off),
        .cfg_wlen  (cfg_wlen),
        .cfg_hlen  (cfg_hlen),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .out_valid (out_valid),
        .axis_o    (axis_o),
        .arrow_o   (arrow_o),
        .tick_o    (tick_o),
        .grid_o    (grid_o),
        .line_o    (line_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // model geometry: active, shadow, pending flag
    int m_off = 7, m_wlen = 600, m_hlen = 450;
    int s_off = 0, s_wlen = 0, s_hlen = 0;
    bit m_pend = 1'b0;

    logic [QW-1:0] exp_q[$];
    logic [4:0]    seen[int];

    typedef struct {
        int         x;
        int         y;
        logic [3:0] flags;   // {axis, arrow, tick, grid}
    } vec_t;

    // ---------------- reference model ----------------
    function automatic logic [3:0] ref_flags(input int x, input int y, input int off,
                                             input int wlen, input int hlen,
                                             input bit e, input bit g);
        int dx, dy, kx, ky;
        bit ax, ar, tk, gr, xin, yin;
        dx  = (x > off) ? x - off : off - x;
        dy  = (y > off) ? y - off : off - y;
        kx  = x - off - wlen;
        ky  = y - off - hlen;
        xin = (x > off) && (x < off + wlen);
        yin = (y > off) && (y < off + hlen);
        ax  = (x >= off && x < off + wlen && dy <= HW) ||
              (y >= off && y < off + hlen && dx <= HW);
        ar  = (kx >= 0 && kx < ARR && dy <= (ARR - kx) / 2) ||
              (ky >= 0 && ky < ARR && dx <= (ARR - ky) / 2);
        tk  = (xin && ((x - off) % TSP == 0) && dy > HW && dy <= HW + TLEN) ||
              (yin && ((y - off) % TSP == 0) && dx > HW && dx <= HW + TLEN);
        gr  = g && xin && yin && (((x - off) % TSP == 0) || ((y - off) % TSP == 0)) && !ax;
        if (!e) return 4'b0000;
        return {ax, ar, tk, gr};
    endfunction

    // ---------------- checks ----------------
    task automatic check_bits(input string name, input logic [7:0] got, input logic [7:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic check_pix(input int x, input int y, input logic [3:0] want);
        int key;
        key = y * SW + x;
        if (!seen.exists(key)) begin
            n_cmp++;
            n_err++;
            $display("FAIL pix(%0d,%0d): not observed, expected %b", x, y, want);
        end else begin
            check_bits($sformatf("pix(%0d,%0d)", x, y), {4'b0, seen[key][4:1]}, {4'b0, want});
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [QW-1:0] mon_e;
    logic [5:0]    mon_got, mon_want;
    int            mon_key;

    always @(negedge clk) begin
        if (rst_n && exp_q.size() >= 3) begin
            mon_e    = exp_q.pop_front();
            mon_got  = {out_valid, axis_o, arrow_o, tick_o, grid_o, line_o};
            mon_want = {mon_e[24], mon_e[4:0]};
            mon_key  = int'(mon_e[23:5]);
            n_cmp++;
            if (mon_got !== mon_want) begin
                n_err++;
                $display("FAIL stream pix(%0d,%0d): got %b expected %b",
                         mon_key % SW, mon_key / SW, mon_got, mon_want);
            end
            if (mon_e[24]) seen[mon_key] = mon_got[4:0];
        end
    end

    // ---------------- driver ----------------
    task automatic drive_cycle(input bit v, input int x, input int y, input bit s,
                               input bit e, input bit g, input bit cv,
                               input int c_off, input int c_wlen, input int c_hlen);
        int         u_off, u_wlen, u_hlen, key;
        logic [3:0] f;
        bit         load;
        @(posedge clk);
        #1;
        check_bits("cfg_ready", {7'b0, cfg_ready}, {7'b0, (m_pend ? 1'b0 : 1'b1)});
        pix_valid = v;
        px        = x[XW-1:0];
        py        = y[YW-1:0];
        sof       = s;
        en        = e;
        grid_en   = g;
        cfg_valid = cv;
        cfg_off   = c_off[YW-1:0];
        cfg_wlen  = c_wlen[XW-1:0];
        cfg_hlen  = c_hlen[YW-1:0];
        load   = m_pend && s && v;
        u_off  = load ? s_off  : m_off;
        u_wlen = load ? s_wlen : m_wlen;
        u_hlen = load ? s_hlen : m_hlen;
        f   = v ? ref_flags(x, y, u_off, u_wlen, u_hlen, e, g) : 4'b0000;
        key = v ? y * SW + x : 0;
        exp_q.push_back({v, key[18:0], f, |f});
        if (load) begin
            m_off  = s_off;
            m_wlen = s_wlen;
            m_hlen = s_hlen;
            m_pend = 1'b0;
        end else if (cv && !m_pend) begin
            s_off  = c_off;
            s_wlen = c_wlen;
            s_hlen = c_hlen;
            m_pend = 1'b1;
        end
    endtask

    task automatic drain();
        repeat (3) drive_cycle(1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 0);
    endtask

    task automatic drive_frame(input int ny, input int nx, input int nx_wide,
                               input int wide_rows, input int wide_extra,
                               input bit rnd, input bit en_fix, input int cfg_line,
                               input int c_off, input int c_wlen, input int c_hlen,
                               input int abort_line);
        seen.delete();
        for (int y = 0; y < ny; y++) begin
            int len;
            if (y == abort_line) return;
            len = (y < wide_rows || y == wide_extra) ? nx_wide : nx;
            for (int x = 0; x < len; x++) begin
                bit e, g, cv;
                int co, cw, ch;
                e  = rnd ? ($urandom_range(0, 7) != 0) : en_fix;
                g  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                cv = (y == cfg_line) && (x == 0);
                co = c_off;
                cw = c_wlen;
                ch = c_hlen;
                if (rnd && $urandom_range(0, 299) == 0) begin
                    cv = 1'b1;
                    co = $urandom_range(0, 60);
                    cw = $urandom_range(1, 1023);
                    ch = $urandom_range(1, 511);
                end
                if (rnd && $urandom_range(0, 9) == 0)
                    drive_cycle(1'b0, x, y, 1'b0, e, g, 1'b0, 0, 0, 0);
                drive_cycle(1'b1, x, y, (x == 0 && y == 0), e, g, cv, co, cw, ch);
            end
            drive_cycle(1'b0, 0, y, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 0);
        end
    endtask

    // ---------------- test sequence ----------------
    vec_t vecs[18];

    initial begin
        vecs[0]  = '{7,   7,   4'b1000};
        vecs[1]  = '{606, 5,   4'b1000};
        vecs[2]  = '{5,   456, 4'b1000};
        vecs[3]  = '{607, 7,   4'b0100};
        vecs[4]  = '{617, 7,   4'b0000};
        vecs[5]  = '{612, 9,   4'b0100};
        vecs[6]  = '{612, 10,  4'b0000};
        vecs[7]  = '{57,  10,  4'b0011};
        vecs[8]  = '{57,  13,  4'b0011};
        vecs[9]  = '{57,  14,  4'b0001};
        vecs[10] = '{58,  11,  4'b0000};
        vecs[11] = '{7,   11,  4'b1000};
        vecs[12] = '{4,   57,  4'b0010};
        vecs[13] = '{57,  200, 4'b0001};
        vecs[14] = '{300, 107, 4'b0001};
        vecs[15] = '{57,  7,   4'b1000};
        vecs[16] = '{57,  460, 4'b0000};
        vecs[17] = '{0,   0,   4'b0000};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check_bits("reset_flags", {2'b0, out_valid, axis_o, arrow_o, tick_o, grid_o, line_o}, 8'h00);
        check_bits("reset_cfg_ready", {7'b0, cfg_ready}, 8'h01);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Frame A: default geometry, grid on, tall frame with a few full-width rows
        drive_frame(470, 60, 640, 14, 107, 1'b0, 1'b1, -1, 0, 0, 0, -1);
        drain();
        for (int i = 0; i < 18; i++) check_pix(vecs[i].x, vecs[i].y, vecs[i].flags);
        check_pix(4, 461, 4'b0100);
        check_pix(7, 457, 4'b0100);

        // Frame B: config request mid-frame keeps old geometry until next sof
        drive_frame(30, 64, 64, 0, -1, 1'b0, 1'b1, 10, 20, 300, 200, -1);
        drain();
        check_pix(7, 25, 4'b1000);
        check_bits("cfg_ready_pending", {7'b0, cfg_ready}, 8'h00);

        // Frame C: new geometry applied from its sof pixel
        drive_frame(30, 64, 64, 0, -1, 1'b0, 1'b1, -1, 0, 0, 0, -1);
        drain();
        check_pix(20, 20, 4'b1000);
        check_pix(7, 7, 4'b0000);
        check_bits("cfg_ready_after_sof", {7'b0, cfg_ready}, 8'h01);

        // Frame D: transfer on the sof cycle itself defers to the next frame
        drive_frame(20, 64, 64, 0, -1, 1'b0, 1'b1, 0, 0, 40, 30, -1);
        drain();
        check_pix(0, 0, 4'b0000);
        check_bits("cfg_ready_sof_xfer", {7'b0, cfg_ready}, 8'h00);

        // Frame E: origin at 0 now active
        drive_frame(20, 64, 64, 0, -1, 1'b0, 1'b1, -1, 0, 0, 0, -1);
        drain();
        check_pix(0, 0, 4'b1000);

        // Frame F: render disabled
        drive_frame(20, 64, 64, 0, -1, 1'b0, 1'b0, -1, 0, 0, 0, -1);
        drain();
        check_pix(0, 0, 4'b0000);
        check_bits("cfg_ready_idle", {7'b0, cfg_ready}, 8'h01);

        // randomized frames: random en/grid_en, bubbles, random config requests
        for (int r = 0; r < 3; r++) begin
            drive_frame(30, 80, 80, 0, -1, 1'b1, 1'b1, -1, 0, 0, 0, -1);
        end
        drive_frame(6, 640, 640, 0, -1, 1'b1, 1'b1, -1, 0, 0, 0, -1);
        drain();

        // Frame G: reset asserted mid-frame with a config request outstanding
        drive_frame(20, 64, 64, 0, -1, 1'b0, 1'b1, 2, 30, 100, 100, 5);
        #2;
        rst_n     = 1'b0;
        pix_valid = 1'b0;
        sof       = 1'b0;
        cfg_valid = 1'b0;
        exp_q.delete();
        m_off  = 7;
        m_wlen = 600;
        m_hlen = 450;
        m_pend = 1'b0;
        #1;
        check_bits("async_reset_flags", {2'b0, out_valid, axis_o, arrow_o, tick_o, grid_o, line_o}, 8'h00);
        check_bits("async_reset_cfg_ready", {7'b0, cfg_ready}, 8'h01);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Frame H: defaults back, dropped config never applied
        drive_frame(40, 64, 64, 0, -1, 1'b0, 1'b1, -1, 0, 0, 0, -1);
        drain();
        check_pix(7, 7, 4'b1000);
        check_pix(30, 30, 4'b0000);
        check_bits("cfg_ready_final", {7'b0, cfg_ready}, 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axes_grid_renderer.md
Name: axes_grid_renderer

Overview:
- Pipelined plot-axes renderer for the 640x480 VGA panel path.
- Consumes the raster pixel stream (coordinates plus valid) and emits per-pixel classification flags: axis, arrowhead, tick mark, grid line.
- Replaces the combinational axes check with registered outputs and runtime-reconfigurable axis geometry, applied only at frame boundaries.
- Adds incremental tick and grid generation that needs no dividers.

Parameters:
- SCREEN_W, 640, horizontal resolution; px width = $clog2(SCREEN_W).
- SCREEN_H, 480, vertical resolution; py width = $clog2(SCREEN_H).
- WIDTH, 5, axis line thickness in pixels (odd); half-width HW = WIDTH/2.
- TICK_SP, 50, pixel spacing between ticks/grid lines (>=2).
- TICK_LEN, 4, tick extent beyond the axis half-width, in pixels.
- DEF_OFF, 7, reset value of the origin offset (same on x and y).
- DEF_WLEN, 600, reset value of the x-axis length.
- DEF_HLEN, 450, reset value of the y-axis length.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- px  in  $clog2(SCREEN_W)  pixel column.
- py  in  $clog2(SCREEN_H)  pixel row.
- pix_valid  in  1  px/py valid (active video); raster order.
- sof  in  1  start of frame; asserted with pix_valid at px=0,py=0.
- en  in  1  global render enable; sampled with the pixel.
- grid_en  in  1  grid-line enable; sampled with the pixel.
- cfg_off  in  $clog2(SCREEN_H)  new origin offset.
- cfg_wlen  in  $clog2(SCREEN_W)  new x-axis length.
- cfg_hlen  in  $clog2(SCREEN_H)  new y-axis length.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config accepted when cfg_valid & cfg_ready.
- out_valid  out  1  pix_valid delayed 2 cycles.
- axis_o  out  1  pixel lies on the x or y axis body.
- arrow_o  out  1  pixel lies on an arrowhead.
- tick_o  out  1  pixel lies on a tick mark.
- grid_o  out  1  pixel lies on a grid line.
- line_o  out  1  OR of the four flags above.

Behaviour:
- Reset: all outputs 0 except cfg_ready=1. Active geometry = DEF_OFF/DEF_WLEN/DEF_HLEN. Phase counters 0. No pending config.
- Config handshake: transfer occurs when cfg_valid & cfg_ready; values go to a shadow register and cfg_ready drops to 0 next cycle. At the next cycle with sof & pix_valid, shadow is copied to active geometry, and that sof pixel already uses the new geometry. cfg_ready returns to 1 the cycle after. Transfer and sof in the same cycle: the new values take effect at the following frame. Only one pending update is held.
- Two-state FSM: IDLE (cfg_ready=1) -> PEND on transfer; PEND -> IDLE on sof & pix_valid. Reset mid-PEND discards the shadow.
- Stage 1 (registered):
  - Absolute distances dx=|px-OFF| and dy=|py-OFF|, computed one bit wider. No unsigned wrap is permitted: pixels left of or above the origin must not match.
  - Range compares and phase counters.
- Phase counters, updated on pix_valid only:
  - xph: cleared when px==OFF, otherwise increments and wraps TICK_SP-1 -> 0.
  - yph: updated only on pixels with px==0 (new line); cleared when py==OFF, otherwise increments with the same wrap.
  - The tick condition uses the post-update phase==0, i.e. px-OFF (resp. py-OFF) is a multiple of TICK_SP.
- Stage 2 (registered flags), all ANDed with en:
  - axis_o: (OFF<=px<OFF+WLEN and dy<=HW) or (OFF<=py<OFF+HLEN and dx<=HW).
  - arrow_o: ARR=2*WIDTH. If OFF+WLEN<=px<OFF+WLEN+ARR, then k=px-OFF-WLEN and dy<=(ARR-k)/2. Symmetric condition on y with HLEN.
  - tick_o: xph==0, OFF<px<OFF+WLEN, and HW<dy<=HW+TICK_LEN. Symmetric on y.
  - grid_o: grid_en, xph==0 or yph==0, within the plot rectangle OFF<px<OFF+WLEN and OFF<py<OFF+HLEN, and not axis_o.
- Latency: exactly 2 clk from pixel in to flags out. Flags are 0 whenever out_valid=0.
- Geometry exceeding screen bounds: comparisons saturate naturally. Nothing is drawn off-screen and no wrap-around is allowed.

Decomposition:
- Shared package axes_pkg: default geometry constants, ARR_LEN function, coordinate width localparams.
- One sub-module, tick_phase_ctr (cleared-on-match, wrapping modulo counter), instantiated twice (x, y).

Test Plan:
- Reset, defaults, full frame -> axis_o at (7,7), (606,5), (5,456); 0 at (607,7) body but arrow_o=1 there; arrow_o=0 at (617,7). Total axis pixel count matches the formula.
- Defaults, TICK_SP=50 -> tick_o=1 at (57,10), (57,13); 0 at (57,14), (58,11), (7,11); y tick at (4,57).
- grid_en=1 -> grid_o=1 at (57,200) and (300,107); 0 at (57,7) (axis) and (57,460) (outside plot).
- Config offset=20, wlen=300 handshake mid-frame -> cfg_ready=0 until the next sof; old geometry kept for the rest of the frame; next frame axis_o=1 at (20,20), 0 at (7,7); cfg_ready=1 after sof.
- Pixel (0,0) with OFF=7 -> no wrap match on any flag; en=0 -> all flags 0 while out_valid keeps toggling.
- Assert rst_n low mid-frame with a pending config -> outputs 0 immediately, defaults restored, pending config dropped.
